// File: rtl/branch_predict_table_pkg.sv
// Shared definitions for the branch prediction table: default sizes,
// the weakly-not-taken init value and the per-entry counter operation.
package branch_predict_table_pkg;

  localparam int DEF_IDX_W  = 6;
  localparam int DEF_CNT_W  = 2;
  localparam int DEF_GHR_W  = 0;
  localparam int DEF_PERF_W = 16;

  // Weakly not-taken is the largest value whose MSB is still clear.
  function automatic int weak_nt_value(int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

  localparam int WEAK_NT_INIT = weak_nt_value(DEF_CNT_W);

  // Operation requested of one saturating counter in a given cycle.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

endpackage

// File: rtl/branch_predict_table_if.sv
// Bundle between the core pipeline (master) and the predictor (slave):
// fetch-side lookup, resolved-branch training and performance counters.
interface branch_predict_table_if
  import branch_predict_table_pkg::*;
#(
  parameter int IDX_W  = DEF_IDX_W,
  parameter int PERF_W = DEF_PERF_W
) ();

  logic              stall;
  logic [31:0]       if_pc;
  logic              pred_taken;
  logic [IDX_W-1:0]  pred_idx;
  logic              upd_valid;
  logic [IDX_W-1:0]  upd_idx;
  logic              upd_taken;
  logic              upd_pred;
  logic [PERF_W-1:0] perf_branches;
  logic [PERF_W-1:0] perf_mispred;

  modport master (
    output stall, if_pc, upd_valid, upd_idx, upd_taken, upd_pred,
    input  pred_taken, pred_idx, perf_branches, perf_mispred
  );

  modport slave (
    input  stall, if_pc, upd_valid, upd_idx, upd_taken, upd_pred,
    output pred_taken, pred_idx, perf_branches, perf_mispred
  );

endinterface

// File: rtl/branch_predict_table_sat_counter.sv
// One table entry: an up/down counter that sticks at zero and all-ones.
// Only the MSB leaves the module since that is the prediction bit.
module sat_counter
  import branch_predict_table_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic    clk,
  input  logic    rst_n,
  input  cnt_op_e op,
  output logic    taken
);

  localparam logic [CNT_W-1:0] INIT = CNT_W'(weak_nt_value(CNT_W));

  logic [CNT_W-1:0] value;

  // Step toward taken or not-taken, refusing to wrap at either end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= INIT;
    end else begin
      case (op)
        CNT_INC: if (value != '1) value <= value + CNT_W'(1);
        CNT_DEC: if (value != '0) value <= value - CNT_W'(1);
        default: value <= value;
      endcase
    end
  end

  assign taken = value[CNT_W-1];

endmodule

// File: rtl/branch_predict_table.sv
// Branch direction predictor: a flop-based table of saturating counters
// indexed by PC, optionally XORed with non-speculative global history.
// Lookup is purely combinational; training happens on the clock edge, so
// a lookup and a training of the same entry in one cycle sees the old value.
module branch_predict_table
  import branch_predict_table_pkg::*;
#(
  parameter int IDX_W  = DEF_IDX_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int GHR_W  = DEF_GHR_W,
  parameter int PERF_W = DEF_PERF_W
) (
  input logic                   clk,
  input logic                   rst_n,
  branch_predict_table_if.slave bus
);

  localparam int ENTRIES = 1 << IDX_W;

  logic              upd_accept;
  logic              upd_mispred;
  logic [IDX_W-1:0]  pc_idx;
  logic [IDX_W-1:0]  hist_ext;
  logic [IDX_W-1:0]  lookup_idx;
  logic              cnt_msb [ENTRIES];
  logic [PERF_W-1:0] branches_q;
  logic [PERF_W-1:0] mispred_q;
  logic              unused_pc_bits;

  assign upd_accept     = bus.upd_valid & ~bus.stall;
  assign upd_mispred    = bus.upd_taken ^ bus.upd_pred;
  assign pc_idx         = bus.if_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{bus.if_pc[31:IDX_W+2], bus.if_pc[1:0]};

  generate
    if (GHR_W > 0) begin : g_hist
      logic [GHR_W-1:0] ghr;

      // Shift each trained outcome into the history, newest in the LSB.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ghr <= '0;
        end else if (upd_accept) begin
          ghr <= GHR_W'({ghr, bus.upd_taken});
        end
      end

      assign hist_ext = IDX_W'(ghr);
    end else begin : g_no_hist
      assign hist_ext = '0;
    end
  endgenerate

  assign lookup_idx     = pc_idx ^ hist_ext;
  assign bus.pred_idx   = lookup_idx;
  assign bus.pred_taken = cnt_msb[lookup_idx];

  generate
    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
      cnt_op_e op;

      assign op = (upd_accept && (bus.upd_idx == IDX_W'(g)))
                  ? (bus.upd_taken ? CNT_INC : CNT_DEC)
                  : CNT_HOLD;

      sat_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .op    (op),
        .taken (cnt_msb[g])
      );
    end
  endgenerate

  // Count trained branches and mispredictions, parking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branches_q <= '0;
      mispred_q  <= '0;
    end else if (upd_accept) begin
      if (branches_q != '1) branches_q <= branches_q + PERF_W'(1);
      if (upd_mispred && (mispred_q != '1)) mispred_q <= mispred_q + PERF_W'(1);
    end
  end

  assign bus.perf_branches = branches_q;
  assign bus.perf_mispred  = mispred_q;

endmodule

// File: tb/tb_branch_predict_table.sv
// Bench for branch_predict_table: a bimodal instance and a 4-bit-history,
// 4-bit-perf instance share one stimulus stream and are compared every
// cycle against a table-of-integers model, with directed literal checks.
module tb_branch_predict_table;
  import branch_predict_table_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [31:0] if_pc;
  logic        upd_valid;
  logic [5:0]  upd_idx;
  logic        upd_taken;
  logic        upd_pred;
  logic        checking = 1'b0;

  int checks = 0;
  int errors = 0;

  int tab_bim [64];
  int tab_gsh [64];
  int ghr;
  int pb_bim, pm_bim, pb_gsh, pm_gsh;

  always #5 clk = ~clk;

  branch_predict_table_if #(.IDX_W(6), .PERF_W(16)) bim_if ();
  branch_predict_table_if #(.IDX_W(6), .PERF_W(4))  gsh_if ();

  assign bim_if.stall     = stall;
  assign bim_if.if_pc     = if_pc;
  assign bim_if.upd_valid = upd_valid;
  assign bim_if.upd_idx   = upd_idx;
  assign bim_if.upd_taken = upd_taken;
  assign bim_if.upd_pred  = upd_pred;
  assign gsh_if.stall     = stall;
  assign gsh_if.if_pc     = if_pc;
  assign gsh_if.upd_valid = upd_valid;
  assign gsh_if.upd_idx   = upd_idx;
  assign gsh_if.upd_taken = upd_taken;
  assign gsh_if.upd_pred  = upd_pred;

  branch_predict_table #(
    .IDX_W(6), .CNT_W(2), .GHR_W(0), .PERF_W(16)
  ) dut_bim (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bim_if.slave)
  );

  branch_predict_table #(
    .IDX_W(6), .CNT_W(2), .GHR_W(4), .PERF_W(4)
  ) dut_gsh (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (gsh_if.slave)
  );

  function automatic int sat_step(int v, logic up);
    if (up) return (v >= 3) ? 3 : v + 1;
    return (v <= 0) ? 0 : v - 1;
  endfunction

  // Reference model: counters as integers, history as an integer.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) begin
        tab_bim[i] <= 1;
        tab_gsh[i] <= 1;
      end
      ghr    <= 0;
      pb_bim <= 0;
      pm_bim <= 0;
      pb_gsh <= 0;
      pm_gsh <= 0;
    end else if (upd_valid && !stall) begin
      tab_bim[upd_idx] <= sat_step(tab_bim[upd_idx], upd_taken);
      tab_gsh[upd_idx] <= sat_step(tab_gsh[upd_idx], upd_taken);
      ghr    <= ((ghr * 2) + int'(upd_taken)) % 16;
      pb_bim <= (pb_bim < 65535) ? pb_bim + 1 : pb_bim;
      pb_gsh <= (pb_gsh < 15) ? pb_gsh + 1 : pb_gsh;
      if (upd_taken != upd_pred) begin
        pm_bim <= (pm_bim < 65535) ? pm_bim + 1 : pm_bim;
        pm_gsh <= (pm_gsh < 15) ? pm_gsh + 1 : pm_gsh;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [31:0] pc, input logic uv,
                               input logic [5:0] ui, input logic ut, input logic up);
    stall     = s;
    if_pc     = pc;
    upd_valid = uv;
    upd_idx   = ui;
    upd_taken = ut;
    upd_pred  = up;
  endtask

  // Every cycle, mid-low-phase, compare both instances against the model.
  always @(negedge clk) begin
    if (checking) begin
      int ib;
      int ig;
      #3;
      ib = int'(if_pc[7:2]);
      ig = ib ^ ghr;
      checkOutput("bim_pred_idx", 32'(bim_if.pred_idx), ib);
      checkOutput("bim_pred_taken", 32'(bim_if.pred_taken), (tab_bim[ib] >= 2) ? 1 : 0);
      checkOutput("bim_perf_branches", 32'(bim_if.perf_branches), pb_bim);
      checkOutput("bim_perf_mispred", 32'(bim_if.perf_mispred), pm_bim);
      checkOutput("gsh_pred_idx", 32'(gsh_if.pred_idx), ig);
      checkOutput("gsh_pred_taken", 32'(gsh_if.pred_taken), (tab_gsh[ig] >= 2) ? 1 : 0);
      checkOutput("gsh_perf_branches", 32'(gsh_if.perf_branches), pb_gsh);
      checkOutput("gsh_perf_mispred", 32'(gsh_if.perf_mispred), pm_gsh);
    end
  end

  initial begin
    logic [31:0] rpc;
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h40, 1'b0, 6'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #4;
    checkOutput("reset_pred_taken", 32'(bim_if.pred_taken), 0);
    checkOutput("reset_pred_idx", 32'(bim_if.pred_idx), 32'h10);
    checkOutput("reset_perf_branches", 32'(bim_if.perf_branches), 0);
    checkOutput("reset_perf_mispred", 32'(bim_if.perf_mispred), 0);
    @(negedge clk);
    rst_n    = 1'b1;
    checking = 1'b1;

    // Same-cycle lookup and taken training at 0x10, then saturation.
    @(negedge clk); applyStimulus(1'b0, 32'h40, 1'b1, 6'h10, 1'b1, 1'b0); #4;
    checkOutput("rbw_same_cycle", 32'(bim_if.pred_taken), 0);
    @(negedge clk); applyStimulus(1'b0, 32'h40, 1'b1, 6'h10, 1'b1, 1'b0); #4;
    checkOutput("after_taken1", 32'(bim_if.pred_taken), 1);
    @(negedge clk); applyStimulus(1'b0, 32'h40, 1'b1, 6'h10, 1'b1, 1'b0); #4;
    checkOutput("after_taken2", 32'(bim_if.pred_taken), 1);
    @(negedge clk); applyStimulus(1'b0, 32'h40, 1'b1, 6'h10, 1'b0, 1'b0); #4;
    checkOutput("after_taken3_sat", 32'(bim_if.pred_taken), 1);
    @(negedge clk); applyStimulus(1'b0, 32'h40, 1'b1, 6'h10, 1'b0, 1'b0); #4;
    checkOutput("after_nt1", 32'(bim_if.pred_taken), 1);
    @(negedge clk); applyStimulus(1'b0, 32'h40, 1'b0, 6'h10, 1'b0, 1'b0); #4;
    checkOutput("after_nt2", 32'(bim_if.pred_taken), 0);
    checkOutput("perf_branches_5", 32'(bim_if.perf_branches), 5);
    checkOutput("perf_mispred_3", 32'(bim_if.perf_mispred), 3);

    // Stalled training must change nothing.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); applyStimulus(1'b1, 32'h40, 1'b1, 6'h10, 1'b1, 1'b0); #4;
      checkOutput("stall_pred", 32'(bim_if.pred_taken), 0);
      checkOutput("stall_perf", 32'(bim_if.perf_branches), 5);
    end
    @(negedge clk); applyStimulus(1'b0, 32'h40, 1'b0, 6'h10, 1'b0, 1'b0); #4;
    checkOutput("post_stall_pred", 32'(bim_if.pred_taken), 0);
    checkOutput("post_stall_mispred", 32'(bim_if.perf_mispred), 3);

    // Mid-cycle reset pulse, then history T,T,N,T.
    rst_n = 1'b0; #1;
    checkOutput("async_rst_branches", 32'(bim_if.perf_branches), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); applyStimulus(1'b0, 32'h40, 1'b1, 6'h3F, 1'b1, 1'b1);
    @(negedge clk); applyStimulus(1'b0, 32'h40, 1'b1, 6'h3F, 1'b1, 1'b1);
    @(negedge clk); applyStimulus(1'b0, 32'h40, 1'b1, 6'h3F, 1'b0, 1'b0);
    @(negedge clk); applyStimulus(1'b0, 32'h40, 1'b1, 6'h3F, 1'b1, 1'b1);
    @(negedge clk); applyStimulus(1'b0, 32'h40, 1'b0, 6'h00, 1'b0, 1'b0); #4;
    checkOutput("ghr_pred_idx", 32'(gsh_if.pred_idx), 32'h1D);
    checkOutput("bim_pred_idx_nohist", 32'(bim_if.pred_idx), 32'h10);

    // Twenty mispredicting updates saturate the 4-bit perf counters.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); applyStimulus(1'b0, 32'h100, 1'b1, 6'($urandom), 1'b1, 1'b0);
    end
    @(negedge clk); applyStimulus(1'b0, 32'h40, 1'b0, 6'h00, 1'b0, 1'b0); #4;
    checkOutput("perf4_branches_sat", 32'(gsh_if.perf_branches), 15);
    checkOutput("perf4_mispred_sat", 32'(gsh_if.perf_mispred), 15);
    checkOutput("perf16_branches", 32'(bim_if.perf_branches), 24);
    checkOutput("perf16_mispred", 32'(bim_if.perf_mispred), 20);

    // Reset pulse landing on a pending update clears and overrides it.
    @(negedge clk); applyStimulus(1'b0, 32'h40, 1'b1, 6'h10, 1'b1, 1'b0); #4;
    rst_n = 1'b0; #1;
    checkOutput("rst_pulse_branches", 32'(gsh_if.perf_branches), 0);
    checkOutput("rst_pulse_mispred", 32'(gsh_if.perf_mispred), 0);
    checkOutput("rst_pulse_pred", 32'(bim_if.pred_taken), 0);
    @(negedge clk); rst_n = 1'b1;
    applyStimulus(1'b0, 32'h40, 1'b0, 6'h00, 1'b0, 1'b0); #4;
    checkOutput("rst_override_branches", 32'(bim_if.perf_branches), 0);
    checkOutput("rst_override_pred", 32'(bim_if.pred_taken), 0);

    // Randomized traffic with occasional stalls and resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 299) != 0);
      rpc = $urandom;
      applyStimulus(($urandom_range(0, 3) == 0), rpc, ($urandom_range(0, 9) < 6),
                    ($urandom_range(0, 1) == 1) ? rpc[7:2] : 6'($urandom),
                    1'($urandom), 1'($urandom));
    end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h40, 1'b0, 6'h00, 1'b0, 1'b0);
    @(negedge clk); #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_table.md
BRANCH_PREDICT_TABLE -- requirements
Module: branch_predict_table

Interface
REQ-001 SHALL have parameter IDX_W, default 6; table holds 2^IDX_W entries.
REQ-002 SHALL have parameter CNT_W, default 2; saturating counter width, legal range 2..4.
REQ-003 SHALL have parameter GHR_W, default 0; global history length, legal range 0..IDX_W; 0 selects pure PC indexing (bimodal mode).
REQ-004 SHALL have parameter PERF_W, default 16; width of the performance counters.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 stall  input  1  pipeline stall; 1 freezes all state updates.
REQ-008 if_pc  input  32  PC of the instruction in IF.
REQ-009 pred_taken  output  1  1 = predict taken, 0 = predict not-taken.
REQ-010 pred_idx  output  IDX_W  table index used for this prediction; carried down the pipe by the core.
REQ-011 upd_valid  input  1  a resolved branch is presented for training this cycle.
REQ-012 upd_idx  input  IDX_W  pred_idx originally issued for the resolved branch.
REQ-013 upd_taken  input  1  actual branch outcome.
REQ-014 upd_pred  input  1  prediction originally issued for the resolved branch.
REQ-015 perf_branches  output  PERF_W  count of accepted updates.
REQ-016 perf_mispred  output  PERF_W  count of accepted updates with upd_taken != upd_pred.

Function
REQ-017 Index SHALL be if_pc[IDX_W+1:2] XOR the zero-extended GHR when GHR_W>0, and if_pc[IDX_W+1:2] when GHR_W=0.
REQ-018 pred_idx and pred_taken SHALL be combinational from if_pc and current state, with zero cycles latency; pred_taken = MSB of the indexed counter.
REQ-019 An update SHALL be accepted only when upd_valid=1 and stall=0.
REQ-020 On an accepted update, counter[upd_idx] SHALL increment on upd_taken=1 and decrement on upd_taken=0, saturating at all-ones and at zero.
REQ-021 On an accepted update with GHR_W>0, GHR SHALL shift left by one with upd_taken entering the LSB; history is non-speculative.
REQ-022 When an update and a prediction address the same index in the same cycle, the prediction SHALL use the pre-update value (read-before-write, no bypass).
REQ-023 On an accepted update, perf_branches SHALL increment by 1, and perf_mispred SHALL increment by 1 if upd_taken != upd_pred; both saturate at all-ones.
REQ-024 With stall=1, counters, GHR and perf counters SHALL hold their values; the prediction outputs stay live.

Reset
REQ-025 On rst_n=0, every counter SHALL take the value 2^(CNT_W-1)-1 (weakly not-taken; 01 for CNT_W=2), immediately and without waiting for a clock edge.
REQ-026 On rst_n=0, GHR, perf_branches and perf_mispred SHALL clear to 0; pred_taken therefore reads 0 during reset.
REQ-027 Reset asserted mid-operation SHALL override any simultaneous update; the first accepted update is on the first rising edge after rst_n=1.

Structure
REQ-028 The shared package SHALL hold the default IDX_W, CNT_W, GHR_W and PERF_W values, plus the weak-not-taken init constant derived from CNT_W.
REQ-029 The per-entry saturating up/down counter SHALL be a sub-module named sat_counter, parametrised by CNT_W and instantiated 2^IDX_W times by generate.
REQ-030 The table SHALL use flops with asynchronous reset, not inferred RAM.

Verification
REQ-031 Reset, then if_pc=0x40: pred_taken=0, pred_idx=0x10, perf counters 0.
REQ-032 Bimodal mode: three taken updates at idx 0x10: counter goes 01->10->11->11, pred_taken=1 after the first update, and the counter saturates.
REQ-033 Same-cycle update (taken) and prediction at idx 0x10 from state 01: pred_taken=0 that cycle, 1 the next cycle.
REQ-034 upd_valid=1 with stall=1 for 3 cycles: no counter, GHR or perf change.
REQ-035 GHR_W=4: updates T,T,N,T give GHR=0b1101; if_pc=0x40 gives pred_idx=0x10^0x0D=0x1D.
REQ-036 PERF_W=4: 20 mispredicting updates: perf_branches=perf_mispred=15 (saturated); rst_n pulse mid-stream clears both asynchronously.
